// File: rtl/vseq_pkg.sv
// Shared definitions for the vector sequencer: vector opcode, element
// function encodings and the sequencer state type.
package vseq_pkg;

    localparam logic [6:0] OP_VECTOR = 7'b1010111;

    localparam logic [1:0] VF_ADD = 2'b00;
    localparam logic [1:0] VF_SUB = 2'b01;
    localparam logic [1:0] VF_AND = 2'b10;
    localparam logic [1:0] VF_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/vector_sequencer.sv
// EX-stage sequencer that streams packed vector elements through a shared
// element ALU and assembles the results. VSEQ_MASK_EN adds per-element masking.
module vector_sequencer
    import vseq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ELEN = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   Valid_i,
    input  logic [6:0]             Op_i,
    input  logic [1:0]             VecFunc_i,
    input  logic [XLEN-1:0]        VecA_i,
    input  logic [XLEN-1:0]        VecB_i,
    input  logic                   Flush_i,
`ifdef VSEQ_MASK_EN
    input  logic [XLEN/ELEN-1:0]   Mask_i,
`endif
    output logic                   ElemReq_o,
    input  logic                   ElemGnt_i,
    output logic [ELEN-1:0]        ElemOpA_o,
    output logic [ELEN-1:0]        ElemOpB_o,
    output logic [1:0]             ElemFunc_o,
    input  logic [ELEN-1:0]        ElemRes_i,
    output logic                   Stall_o,
    output logic                   Busy_o,
    output logic                   Done_o,
    output logic [XLEN-1:0]        Result_o
);

    localparam int NE   = XLEN / ELEN;
    localparam int IDXW = $clog2(NE);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NE - 1);

    state_t            state;
    state_t            next_state;
    logic [IDXW-1:0]   idx;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [1:0]        func;
    logic              start;
    logic              elem_req;
    logic              advance;
    logic [ELEN-1:0]   elem_data;
`ifdef VSEQ_MASK_EN
    logic [NE-1:0]     mask;
`endif

    // A masked-off element advances on its own and contributes zero;
    // an enabled element advances only when the ALU grants it.
    always_comb begin
        next_state = state;
        elem_req   = 1'b0;
        advance    = 1'b0;
        elem_data  = ElemRes_i;
        start      = (state == IDLE) && Valid_i && (Op_i == OP_VECTOR) && !Flush_i;

        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                elem_req = 1'b1;
`ifdef VSEQ_MASK_EN
                if (!mask[idx]) begin
                    elem_req = 1'b0;
                end
`endif
                advance   = elem_req ? ElemGnt_i : 1'b1;
                elem_data = elem_req ? ElemRes_i : '0;
                if (Flush_i) begin
                    next_state = IDLE;
                end else if (advance && (idx == IDX_LAST)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            func  <= '0;
`ifdef VSEQ_MASK_EN
            mask  <= '0;
`endif
        end else begin
            state <= next_state;
            if (start) begin
                op_a <= VecA_i;
                op_b <= VecB_i;
                func <= VecFunc_i;
`ifdef VSEQ_MASK_EN
                mask <= Mask_i;
`endif
                idx  <= '0;
                acc  <= '0;
            end else if ((state == ISSUE) && advance && !Flush_i) begin
                // Flush wins over a coincident grant, so the element is dropped
                acc[idx*ELEN +: ELEN] <= elem_data;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    assign ElemReq_o  = elem_req;
    assign ElemOpA_o  = op_a[idx*ELEN +: ELEN];
    assign ElemOpB_o  = op_b[idx*ELEN +: ELEN];
    assign ElemFunc_o = func;
    assign Stall_o    = start || (state == ISSUE);
    assign Busy_o     = (state != IDLE);
    assign Done_o     = (state == DONE) && !Flush_i;
    assign Result_o   = acc;

endmodule
